// File: rtl/segre_pkg.sv
// segre_pkg: shared core widths, memory access sizes and arbiter state/client types
package segre_pkg;
  localparam int ADDR_SIZE = 32;
  localparam int CACHE_LINE_SIZE_BYTES = 16;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memop_data_type_e;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2,
    RESP     = 2'd3
  } arb_state_e;
  typedef enum logic {
    ARB_IF  = 1'b0,
    ARB_MEM = 1'b1
  } arb_client_e;
endpackage

// File: rtl/segre_mem_arbiter_if.sv
// segre_mem_arbiter_if: IF/MEM client requests and external memory port; slave = arbiter, master = clients + memory
interface segre_mem_arbiter_if;
  import segre_pkg::*;
  logic if_rd_i;
  logic [ADDR_SIZE-1:0] if_addr_i;
  logic if_ready_o;
  logic [CACHE_LINE_SIZE_BYTES*8-1:0] if_data_o;
  logic mem_rd_i;
  logic mem_wr_i;
  logic [ADDR_SIZE-1:0] mem_addr_i;
  memop_data_type_e mem_data_type_i;
  logic [CACHE_LINE_SIZE_BYTES*8-1:0] mem_wr_data_i;
  logic mem_ready_o;
  logic [CACHE_LINE_SIZE_BYTES*8-1:0] mem_data_o;
  logic [ADDR_SIZE-1:0] addr_o;
  logic rd_o;
  logic wr_o;
  memop_data_type_e data_type_o;
  logic [CACHE_LINE_SIZE_BYTES*8-1:0] wr_data_o;
  logic [CACHE_LINE_SIZE_BYTES*8-1:0] rd_data_i;
  logic ready_i;
  modport slave (
    input  if_rd_i, if_addr_i, mem_rd_i, mem_wr_i, mem_addr_i, mem_data_type_i, mem_wr_data_i, rd_data_i, ready_i,
    output if_ready_o, if_data_o, mem_ready_o, mem_data_o, addr_o, rd_o, wr_o, data_type_o, wr_data_o
  );
  modport master (
    output if_rd_i, if_addr_i, mem_rd_i, mem_wr_i, mem_addr_i, mem_data_type_i, mem_wr_data_i, rd_data_i, ready_i,
    input  if_ready_o, if_data_o, mem_ready_o, mem_data_o, addr_o, rd_o, wr_o, data_type_o, wr_data_o
  );
endinterface

// File: rtl/segre_arb_grant.sv
// segre_arb_grant: picks the winning client; SEGRE_ARB_ROUND_ROBIN_EN alternates on conflict, else MEM always wins
module segre_arb_grant
  import segre_pkg::*;
(
  input  logic        if_req,
  input  logic        mem_req,
  input  arb_client_e last,
  output arb_client_e grant
);
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
  always_comb grant = (if_req && mem_req) ? (last == ARB_IF ? ARB_MEM : ARB_IF) : (mem_req ? ARB_MEM : ARB_IF);
`else
  logic unused_last;
  assign unused_last = last;
  always_comb grant = (mem_req || !if_req) ? ARB_MEM : ARB_IF;
`endif
endmodule

// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: grants IF or MEM one memory transaction at a time (clk_i, rsn_i sync active-high, bus = client + memory ports; SEGRE_ARB_ROUND_ROBIN_EN selects round-robin)
module segre_mem_arbiter
  import segre_pkg::*;
(
  input logic clk_i,
  input logic rsn_i,
  segre_mem_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_IF   = IF_BUSY;
  localparam logic [1:0] S_MEM  = MEM_BUSY;
  localparam logic [1:0] S_RESP = RESP;
  logic [1:0] state;
  arb_client_e last, grant;
  logic mem_req;
  logic [ADDR_SIZE-1:0] addr_q;
  logic rd_q, wr_q;
  memop_data_type_e dt_q;
  logic [CACHE_LINE_SIZE_BYTES*8-1:0] wdata_q, if_data_q, mem_data_q;
  assign mem_req = bus.mem_rd_i || bus.mem_wr_i;
  segre_arb_grant u_grant (
    .if_req (bus.if_rd_i),
    .mem_req(mem_req),
    .last   (last),
    .grant  (grant)
  );
  // last doubles as the currently granted client while BUSY/RESP
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state      <= S_IDLE;
      last       <= ARB_IF;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      dt_q       <= WORD;
      wdata_q    <= '0;
      if_data_q  <= '0;
      mem_data_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.if_rd_i || mem_req) begin
          last <= grant;
          if (grant == ARB_MEM) begin
            state   <= S_MEM;
            addr_q  <= bus.mem_addr_i;
            rd_q    <= !bus.mem_wr_i;
            wr_q    <= bus.mem_wr_i;
            dt_q    <= bus.mem_data_type_i;
            wdata_q <= bus.mem_wr_data_i;
          end else begin
            state   <= S_IF;
            addr_q  <= bus.if_addr_i;
            rd_q    <= 1'b1;
            wr_q    <= 1'b0;
            dt_q    <= WORD;
            wdata_q <= '0;
          end
        end
        S_IF, S_MEM: if (bus.ready_i) begin
          state <= S_RESP;
          rd_q  <= 1'b0;
          wr_q  <= 1'b0;
          if (state == S_IF) if_data_q <= bus.rd_data_i;
          else mem_data_q <= wr_q ? '0 : bus.rd_data_i;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  assign bus.addr_o      = addr_q;
  assign bus.rd_o        = rd_q;
  assign bus.wr_o        = wr_q;
  assign bus.data_type_o = dt_q;
  assign bus.wr_data_o   = wdata_q;
  assign bus.if_data_o   = if_data_q;
  assign bus.mem_data_o  = mem_data_q;
  assign bus.if_ready_o  = state == S_RESP && last == ARB_IF;
  assign bus.mem_ready_o = state == S_RESP && last == ARB_MEM;
  // simultaneous read and write from MEM is a client bug; it is serviced as a write
  assert property (@(posedge clk_i) disable iff (rsn_i) !(bus.mem_rd_i && bus.mem_wr_i));
endmodule

// File: doc/segre_mem_arbiter.md
# segre_mem_arbiter

Arbiter between the core's two memory clients, the IF stage (instruction line fetch) and the MEM stage (data cache line fill and write-back), and the single external memory port. It grants one transaction at a time and holds address, control and write data stable until memory signals ready. It then returns the read line and a one-cycle ready pulse to the granted client. It sits at the core top level, directly downstream of the IF and MEM stages and in front of the core's memory outputs.

## Interface
Parameters: none. Widths come from `segre_pkg` (`ADDR_SIZE`, `CACHE_LINE_SIZE_BYTES`, `memop_data_type_e`).

- clk_i  in  1  core clock
- rsn_i  in  1  reset; synchronous, active-high (1 = reset)
- if_rd_i  in  1  IF read request, held until if_ready_o
- if_addr_i  in  ADDR_SIZE  IF line address
- if_ready_o  out  1  one-cycle pulse, if_data_o valid
- if_data_o  out  CACHE_LINE_SIZE_BYTES x 8  fetched line
- mem_rd_i  in  1  MEM read request, held until mem_ready_o
- mem_wr_i  in  1  MEM write request, held until mem_ready_o
- mem_addr_i  in  ADDR_SIZE  MEM address
- mem_data_type_i  in  memop_data_type_e  MEM access size
- mem_wr_data_i  in  CACHE_LINE_SIZE_BYTES x 8  write line
- mem_ready_o  out  1  one-cycle pulse, transaction done
- mem_data_o  out  CACHE_LINE_SIZE_BYTES x 8  read line; 0 on writes
- addr_o  out  ADDR_SIZE  memory address
- rd_o  out  1  memory read strobe
- wr_o  out  1  memory write strobe
- data_type_o  out  memop_data_type_e  memory access size
- wr_data_o  out  CACHE_LINE_SIZE_BYTES x 8  memory write data
- rd_data_i  in  CACHE_LINE_SIZE_BYTES x 8  memory read data
- ready_i  in  1  memory done; valid only while rd_o or wr_o is high

## Operation
States:
- IDLE → MEM_BUSY when mem_rd_i or mem_wr_i is high and MEM wins arbitration.
- IDLE → IF_BUSY when if_rd_i is high and IF wins arbitration.
- IF_BUSY or MEM_BUSY → RESP when ready_i is high.
- RESP → IDLE unconditionally.

Behaviour:
- On grant, the request is registered. addr_o, rd_o, wr_o, data_type_o and wr_data_o are driven from registers and stay constant for the whole BUSY state.
- IF grants always use data_type_o = WORD, wr_o = 0 and wr_data_o = 0.
- mem_rd_i and mem_wr_i both high: the arbiter treats it as a write and a simulation assertion fires.
- On ready_i, rd_data_i is captured into the granted client's data register.
- RESP: the granted client's ready_o is 1 for exactly one cycle. rd_o and wr_o are 0, and requests are ignored. The client drops its request at the edge that ends this cycle.
- ready_i sampled in IDLE or RESP is ignored.
- The data outputs hold their last captured value until the next capture. mem_data_o is cleared to 0 when a write completes.

## Timing
- Request seen at edge t in IDLE → strobe on the memory port from t+1.
- ready_i high at edge k → client ready_o high during cycle k+1.
- Next grant is decided at edge k+2.
- Minimum transaction is 3 cycles (grant, memory ready in the same cycle as the strobe, RESP).
- Reset values:
  - State IDLE.
  - All strobes and ready outputs 0.
  - addr_o 0, wr_data_o 0, if_data_o 0, mem_data_o 0.
  - data_type_o WORD.
- Reset mid-transaction: returns to IDLE next cycle. The in-flight transaction is abandoned with no ready pulse, and a late ready_i is ignored.

## Configuration
- `SEGRE_ARB_ROUND_ROBIN_EN` defined: when both clients request in IDLE, the client that was not granted last wins. The last-grant flag resets to IF, so MEM wins the first conflict.
- Undefined: fixed priority, MEM always wins a conflict because it holds the older instruction.
- A lone requester is granted in both modes.

## Structure
- Add `arb_state_e` (IDLE, IF_BUSY, MEM_BUSY, RESP) and `arb_client_e` (ARB_IF, ARB_MEM) to `segre_pkg`.
- Reuse the existing package constants; add no local widths.
- One combinational sub-module, `segre_arb_grant`: takes both requests and the last-grant flag, returns the winning client. The macro is evaluated only there.

## Test plan
- IF only: if_rd_i=1, if_addr_i=0x100, ready_i asserted 2 cycles after rd_o → addr_o=0x100 and rd_o=1 for those cycles, data_type_o=WORD, one if_ready_o pulse, if_data_o equals rd_data_i.
- MEM write: mem_wr_i=1, mem_addr_i=0x2000, wr_data_o pattern 0xA5 bytes, ready_i after 5 cycles → wr_o=1 for exactly those cycles with data stable, mem_ready_o pulses once, mem_data_o=0.
- Conflict: both request in the same cycle → MEM granted first and IF granted at the edge after RESP. With `SEGRE_ARB_ROUND_ROBIN_EN`, a second conflict grants IF first.
- Held request: client keeps its request high through RESP → exactly one transaction and one ready pulse, with no duplicate grant.
- Spurious ready: ready_i=1 while in IDLE → no state change and no ready pulse.
- Reset mid-op: rsn_i=1 during MEM_BUSY, then ready_i=1 → all outputs return to reset values, and neither ready_o pulses.
